// File: rtl/ov7670_pattern_source.sv
// OV7670-style parallel video source: pclk/vsync/href/8-bit data carrying RGB565 test patterns.
// Everything advances on pclk falling edges ("ticks"), so data is stable at every pclk rise.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no frame in flight; waits for enable on a tick
// S_VSYNC  | VSYNC_LINES line periods with vsync high
// S_VBACK  | V_BACK blank line periods after vsync
// S_ACTIVE | V_ACTIVE lines: 2*H_ACTIVE href bytes, then H_BLANK blank ticks
// S_VFRONT | V_FRONT blank line periods; frame ends on its last tick
module ov7670_pattern_source #(
    parameter int          H_ACTIVE    = 320,
    parameter int          V_ACTIVE    = 240,
    parameter int          H_BLANK     = 144,
    parameter int          VSYNC_LINES = 3,
    parameter int          V_BACK      = 17,
    parameter int          V_FRONT     = 10,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] patternSel,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] cameraData,
    output logic       frameDone,
    output logic       busy
);

    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int TW         = $clog2(LINE_TICKS);
    localparam int MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LW         = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int RW         = ($clog2(V_ACTIVE) > 8) ? $clog2(V_ACTIVE) : 8;
    localparam int COL_W      = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
    localparam int BAR_W      = H_ACTIVE / 8;
    localparam int BW         = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(LINE_TICKS - 1);
    localparam logic [TW-1:0] HB_T      = TW'(H_BLANK);
    localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VB_LAST   = LW'((V_BACK > 0) ? V_BACK - 1 : 0);
    localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST   = LW'((V_FRONT > 0) ? V_FRONT - 1 : 0);
    localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    localparam state_t LAST_STATE = (V_FRONT > 0) ? S_VFRONT : S_ACTIVE;

    logic             phase;
    state_t           state;
    logic [TW-1:0]    tick_cnt;
    logic [LW-1:0]    line_cnt;
    logic [RW-1:0]    row;
    logic [COL_W-1:0] col;
    logic             lo_byte;
    logic [2:0]       bar_idx;
    logic [BW-1:0]    bar_left;
    logic [1:0]       pat;

    state_t           nxt_state;
    logic [TW-1:0]    nxt_tick;
    logic [LW-1:0]    nxt_line;
    logic [RW-1:0]    nxt_row;
    logic [COL_W-1:0] nxt_col;
    logic             nxt_lo;
    logic [2:0]       nxt_bar;
    logic [BW-1:0]    nxt_bar_left;
    logic             start;
    logic             nxt_last;
    logic             nxt_href;
    logic [15:0]      pix;
    logic [7:0]       nxt_data;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Position of the tick period that begins on the coming tick.
    always_comb begin
        start        = 1'b0;
        nxt_state    = state;
        nxt_tick     = tick_cnt;
        nxt_line     = line_cnt;
        nxt_row      = row;
        nxt_col      = col;
        nxt_lo       = lo_byte;
        nxt_bar      = bar_idx;
        nxt_bar_left = bar_left;
        if (state == S_IDLE) begin
            start = enable;
        end else if (tick_cnt != '0) begin
            nxt_tick = tick_cnt - TW'(1);
            if (lo_byte) begin
                nxt_lo  = 1'b0;
                nxt_col = col + COL_W'(1);
                if (bar_left == '0) begin
                    nxt_bar      = bar_idx + 3'd1;
                    nxt_bar_left = BAR_LAST;
                end else begin
                    nxt_bar_left = bar_left - BW'(1);
                end
            end else begin
                nxt_lo = 1'b1;
            end
        end else begin
            nxt_tick     = TICK_LAST;
            nxt_col      = '0;
            nxt_lo       = 1'b0;
            nxt_bar      = '0;
            nxt_bar_left = BAR_LAST;
            if (line_cnt != '0) begin
                nxt_line = line_cnt - LW'(1);
                if (state == S_ACTIVE) nxt_row = row + RW'(1);
            end else begin
                case (state)
                    S_VSYNC: begin
                        if (V_BACK > 0) begin
                            nxt_state = S_VBACK;
                            nxt_line  = VB_LAST;
                        end else begin
                            nxt_state = S_ACTIVE;
                            nxt_line  = VA_LAST;
                            nxt_row   = '0;
                        end
                    end
                    S_VBACK: begin
                        nxt_state = S_ACTIVE;
                        nxt_line  = VA_LAST;
                        nxt_row   = '0;
                    end
                    S_ACTIVE: begin
                        if (V_FRONT > 0) begin
                            nxt_state = S_VFRONT;
                            nxt_line  = VF_LAST;
                        end else begin
                            start = 1'b1;
                        end
                    end
                    default: start = 1'b1;
                endcase
            end
        end
        if (start) begin
            nxt_state = S_VSYNC;
            nxt_tick  = TICK_LAST;
            nxt_line  = VS_LAST;
        end
    end

    assign nxt_last = (nxt_state == LAST_STATE) && (nxt_line == '0) && (nxt_tick == '0);
    assign nxt_href = (nxt_state == S_ACTIVE) && (nxt_tick >= HB_T);

    always_comb begin
        case (pat)
            2'd0:    pix = bar_color(nxt_bar);
            2'd1:    pix = {nxt_row[7:0], nxt_col[7:0]};
            default: pix = SOLID_COLOR;
        endcase
    end

    assign nxt_data = nxt_href ? (nxt_lo ? pix[7:0] : pix[15:8]) : 8'h00;
    assign pclk     = phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= 1'b0;
            state      <= S_IDLE;
            tick_cnt   <= '0;
            line_cnt   <= '0;
            row        <= '0;
            col        <= '0;
            lo_byte    <= 1'b0;
            bar_idx    <= '0;
            bar_left   <= '0;
            pat        <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            cameraData <= 8'h00;
            frameDone  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            phase     <= ~phase;
            frameDone <= 1'b0;
            if (phase) begin
                tick_cnt   <= nxt_tick;
                line_cnt   <= nxt_line;
                row        <= nxt_row;
                col        <= nxt_col;
                lo_byte    <= nxt_lo;
                bar_idx    <= nxt_bar;
                bar_left   <= nxt_bar_left;
                vsync      <= (nxt_state == S_VSYNC);
                href       <= nxt_href;
                cameraData <= nxt_data;
                frameDone  <= nxt_last;
                if (start) pat <= patternSel;
                // The final tick of the frame is blank, so idling through it looks identical.
                if (nxt_last && !enable) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= nxt_state;
                    busy  <= (nxt_state != S_IDLE);
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pattern_source.sv
// Bench for ov7670_pattern_source: hand-computed vector table plus a position-based frame model.
module tb_ov7670_pattern_source;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HB = 4;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LT = 2 * HA + HB;
    localparam int FT = (VS + VB + VA + VF) * LT;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] patternSel;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] cameraData;
    logic       frameDone;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic tb_phase = 1'b0;

    logic       cap_v    [FT];
    logic       cap_h    [FT];
    logic [7:0] cap_d    [FT];
    logic       cap_fd   [FT];
    logic       cap_busy [FT];

    logic [15:0] bars_tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct {
        int         pat;
        int         t;
        logic       v;
        logic       h;
        logic [7:0] d;
    } vec_t;

    vec_t vecs[$];

    ov7670_pattern_source #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .SOLID_COLOR(16'hF800)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .patternSel(patternSel),
        .pclk(pclk), .vsync(vsync), .href(href), .cameraData(cameraData),
        .frameDone(frameDone), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tb_phase <= 1'b0;
        else       tb_phase <= ~tb_phase;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) check("pclk_phase", {31'd0, pclk}, {31'd0, tb_phase});

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] model(input int pat, input int t);
        int line, p, row, col;
        logic [15:0] pix;
        logic v, h;
        logic [7:0] d;
        line = t / LT;
        p    = t % LT;
        v    = (line < VS);
        h    = 1'b0;
        d    = 8'h00;
        if (line >= VS + VB && line < VS + VB + VA && p < 2 * HA) begin
            row = line - VS - VB;
            col = p / 2;
            case (pat)
                0:       pix = bars_tbl[col / (HA / 8)];
                1:       pix = {row[7:0], col[7:0]};
                default: pix = 16'hF800;
            endcase
            h = 1'b1;
            d = (p % 2 == 0) ? pix[15:8] : pix[7:0];
        end
        return {v, h, d};
    endfunction

    task automatic next_tick();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (tb_phase == 1'b0) break;
        end
    endtask

    task automatic capture_frame(input bit drop_en, input int chg_t, input logic [1:0] chg_val);
        for (int t = 0; t < FT; t++) begin
            if (t > 0) next_tick();
            cap_v[t]    = vsync;
            cap_h[t]    = href;
            cap_d[t]    = cameraData;
            cap_fd[t]   = frameDone;
            cap_busy[t] = busy;
            if (t == 0 && drop_en) enable = 1'b0;
            if (t == chg_t) patternSel = chg_val;
        end
        @(posedge clk);
        #1;
        check("frameDone_one_clk", {31'd0, frameDone}, 32'd0);
    endtask

    task automatic check_frame(input int pat, input bit cont);
        int nfd;
        int first_bad;
        nfd = 0;
        first_bad = -1;
        for (int t = 0; t < FT; t++) begin
            check($sformatf("p%0d_t%0d_vhd", pat, t), {22'd0, cap_v[t], cap_h[t], cap_d[t]},
                  {22'd0, model(pat, t)});
            if (cap_fd[t]) nfd++;
            if (first_bad < 0 && cap_busy[t] !== ((t < FT - 1) || cont)) first_bad = t;
        end
        check($sformatf("p%0d_frameDone_last", pat), {31'd0, cap_fd[FT-1]}, 32'd1);
        check($sformatf("p%0d_frameDone_count", pat), nfd, 32'd1);
        check($sformatf("p%0d_busy_first_bad_tick", pat), first_bad, -1);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pat == pat) begin
                check($sformatf("vec_p%0d_t%0d", pat, vecs[i].t),
                      {22'd0, cap_v[vecs[i].t], cap_h[vecs[i].t], cap_d[vecs[i].t]},
                      {22'd0, vecs[i].v, vecs[i].h, vecs[i].d});
            end
        end
    endtask

    initial begin
        int bad;
        vecs.push_back('{0,   0, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{0,  39, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{0,  40, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{0,  60, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{0,  63, 1'b0, 1'b1, 8'hE0});
        vecs.push_back('{0,  64, 1'b0, 1'b1, 8'h07});
        vecs.push_back('{0,  69, 1'b0, 1'b1, 8'h1F});
        vecs.push_back('{0,  75, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{0,  76, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{0, 120, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{0, 139, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{0, 159, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1,  61, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1,  82, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1,  83, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1, 100, 1'b0, 1'b1, 8'h02});
        vecs.push_back('{1, 101, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1, 103, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1, 114, 1'b0, 1'b1, 8'h02});
        vecs.push_back('{1, 115, 1'b0, 1'b1, 8'h07});
        vecs.push_back('{1, 116, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{2,  60, 1'b0, 1'b1, 8'hF8});
        vecs.push_back('{2,  61, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{2, 134, 1'b0, 1'b1, 8'hF8});
        vecs.push_back('{2, 135, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{2, 136, 1'b0, 1'b0, 8'h00});

        // Reset held with enable high: everything stays zero.
        reset      = 1'b1;
        enable     = 1'b1;
        patternSel = 2'd0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, pclk, vsync, href, cameraData, frameDone, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_e1_pclk_vsync", {30'd0, pclk, vsync}, 32'b10);
        @(posedge clk);
        #1;
        check("release_e2_pclk_vsync", {30'd0, pclk, vsync}, 32'b01);

        // Frame 1: color bars, enable pulsed only for the start tick.
        capture_frame(1'b1, -1, 2'd0);
        check_frame(0, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            next_tick();
            if (vsync || busy || href) bad++;
        end
        check("idle_after_single_frame", bad, 32'd0);

        // Coordinate ramp.
        patternSel = 2'd1;
        enable     = 1'b1;
        next_tick();
        capture_frame(1'b1, -1, 2'd0);
        check_frame(1, 1'b0);

        // Back-to-back frames with a mid-frame pattern change.
        patternSel = 2'd0;
        enable     = 1'b1;
        next_tick();
        capture_frame(1'b0, 50, 2'd2);
        check_frame(0, 1'b1);
        next_tick();
        capture_frame(1'b1, -1, 2'd0);
        check_frame(2, 1'b0);

        // Reset in the middle of an active line, then a clean restart.
        patternSel = 2'd1;
        enable     = 1'b1;
        next_tick();
        repeat (69) next_tick();
        check("pre_reset_href", {31'd0, href}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midline_reset_outputs", {19'd0, pclk, vsync, href, cameraData, frameDone, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("restart_e1_pclk_vsync", {30'd0, pclk, vsync}, 32'b10);
        @(posedge clk);
        #1;
        check("restart_e2_pclk_vsync", {30'd0, pclk, vsync}, 32'b01);
        capture_frame(1'b1, -1, 2'd0);
        check_frame(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
